// File: rtl/serial_sub_arbiter.sv
// Round-robin arbiter for two requesters sharing one bit-serial full-subtractor cell, LSB first.
// Latency: operands accepted at edge E0, res_valid high after edge E0+WIDTH, minimum WIDTH+2 cycles per op.
// Backpressure: res_ready low holds DONE and the result indefinitely; no request is accepted outside IDLE.
module serial_sub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_diff,
    output logic             res_borrow,
    output logic             res_id,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             id_q;
    logic [CW-1:0]    count;

    logic grant;
    logic idle;
    logic bit_d;
    logic bit_b;

    always_comb begin
        // Gated with rst_n so neither requester sees a ready while reset is held.
        idle       = rst_n && (state == IDLE);
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = idle && req0_valid && !grant;
        req1_ready = idle && req1_valid && grant;
        bit_d      = a_sh[0] ^ b_sh[0] ^ borrow_q;
        bit_b      = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_sh       <= '0;
            b_sh       <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            id_q       <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_sh       <= grant ? req1_a : req0_a;
                        b_sh       <= grant ? req1_b : req0_b;
                        borrow_q   <= 1'b0;
                        count      <= '0;
                        id_q       <= grant;
                        last_grant <= grant;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    diff_q   <= {bit_d, diff_q[WIDTH-1:1]};
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    borrow_q <= bit_b;
                    count    <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid  = (state == DONE);
    assign res_diff   = diff_q;
    assign res_borrow = borrow_q;
    assign res_id     = id_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_sub_arbiter.sv
// Bench for serial_sub_arbiter: directed and random operations against an arithmetic reference model.
module tb_serial_sub_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_diff;
    logic         res_borrow;
    logic         res_id;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    bit model_last = 1'b1;

    always #5 clk = ~clk;

    serial_sub_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_diff(res_diff),
        .res_borrow(res_borrow), .res_id(res_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: present requests, check grant, latency, result and handshake.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int hold);
        bit            g;
        logic [W-1:0]  ea, eb, ed;
        bit            eborrow;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = (hold == 0);
        g  = (v0 && v1) ? !model_last : v1;
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        ed = W'(ea - eb);
        eborrow = (ea < eb);
        #1;
        chk("ready0", req0_ready, !g);
        chk("ready1", req1_ready, g);
        tick();
        model_last = g;
        // Losing requester keeps valid; inputs scrambled to prove capture on accept.
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        chk("busy_shift", busy, 1);
        chk("no_ready_shift", {req0_ready, req1_ready}, 0);
        repeat (W - 1) tick();
        chk("valid_early", res_valid, 0);
        tick();
        chk("valid_rise", res_valid, 1);
        chk("diff", res_diff, ed);
        chk("borrow", res_borrow, eborrow);
        chk("id", res_id, g);
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_diff", res_diff, ed);
            chk("hold_borrow", res_borrow, eborrow);
            chk("hold_id", res_id, g);
            chk("hold_ready", {req0_ready, req1_ready}, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("idle_after", {res_valid, busy}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_outputs", {res_valid, res_diff, res_borrow, res_id, busy}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op(1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 0);
        run_op(0, 1, 8'h00, 8'h00, 8'h03, 8'h05, 0);
        run_op(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_op(0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        run_op(1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
        run_op(1, 0, 8'h80, 8'h01, 8'h00, 8'h00, 5);
        // Tie sequences: last winner was req0, so req1 wins, then req0.
        run_op(1, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0);
        run_op(1, 1, 8'h55, 8'h66, 8'h77, 8'h10, 0);

        // Asynchronous reset in the middle of SHIFT.
        req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h01;
        tick();
        req0_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst", {res_valid, res_diff, res_borrow, res_id, busy}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("async_rst_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(1, 1, 8'h0A, 8'h0B, 8'h20, 8'h01, 0);

        for (int n = 0; n < 20; n++) begin
            bit rv0, rv1;
            rv0 = 1'($urandom);
            rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            run_op(rv0, rv1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
